rv_inst_encoder: RTL and testbench

Buffered RV32I instruction encoder, the inverse of the control decoder. It accepts symbolic instruction requests (operation, register indices, full-width immediate) and assembles the 32-bit instruction word. Results are queued in an output FIFO for instruction memory preload, self-test, and debug injection into the single-cycle core. It covers exactly the instruction set the core decodes, so every word it emits is legal for the core.

---
 rtl/rv_inst_encoder.sv | 164 ++++++++++++++++
 tb/tb_rv_inst_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: assembles RV32I instruction words from symbolic requests
// and queues them in a small output FIFO. Rejected requests raise a
// one-cycle error pulse instead of being queued.
// Build option: define ENCODER_RANGE_CHECK_EN to range-check immediates and
// the alignment of branch/jump offsets; otherwise immediates are truncated.
module rv_inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_OP    = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [31:0]   enc_word;
  logic [1:0]    enc_err;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic          push, pop, accept;

  // funct3/funct7 selection shared by the R, I, S and B formats
  always_comb begin
    f3 = 3'b000;
    case (in_op)
      5'd5, 5'd12, 5'd19:        f3 = 3'b001;
      5'd15, 5'd17:              f3 = 3'b010;
      5'd4, 5'd11, 5'd20:        f3 = 3'b100;
      5'd6, 5'd7, 5'd13, 5'd14,
      5'd21:                     f3 = 3'b101;
      5'd3, 5'd10:               f3 = 3'b110;
      5'd2, 5'd9:                f3 = 3'b111;
      default:                   f3 = 3'b000;
    endcase
    f7 = (in_op == 5'd1 || in_op == 5'd7 || in_op == 5'd14) ? 7'b0100000 : 7'b0000000;
  end

  // Field-packing mux and (optionally) immediate legality check
  always_comb begin
    enc_word = '0;
    enc_err  = ERR_NONE;
    case (in_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7:
        enc_word = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16: begin
        enc_word = {in_imm[11:0], in_rs1, f3, in_rd,
                    (in_op == 5'd15) ? 7'b0000011 :
                    (in_op == 5'd16) ? 7'b1100111 : 7'b0010011};
`ifdef ENCODER_RANGE_CHECK_EN
        if (!(&in_imm[31:11] || ~|in_imm[31:11])) enc_err = ERR_RANGE;
`endif
      end
      5'd12, 5'd13, 5'd14: begin
        enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
`ifdef ENCODER_RANGE_CHECK_EN
        if (|in_imm[31:5]) enc_err = ERR_RANGE;
`endif
      end
      5'd17: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
`ifdef ENCODER_RANGE_CHECK_EN
        if (!(&in_imm[31:11] || ~|in_imm[31:11])) enc_err = ERR_RANGE;
`endif
      end
      5'd18, 5'd19, 5'd20, 5'd21: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
`ifdef ENCODER_RANGE_CHECK_EN
        if (in_imm[0])                                    enc_err = ERR_ALIGN;
        else if (!(&in_imm[31:12] || ~|in_imm[31:12]))   enc_err = ERR_RANGE;
`endif
      end
      5'd22: begin
        enc_word = {in_imm[31:12], in_rd, 7'b0110111};
`ifdef ENCODER_RANGE_CHECK_EN
        if (|in_imm[11:0]) enc_err = ERR_RANGE;
`endif
      end
      5'd23: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, 7'b1101111};
`ifdef ENCODER_RANGE_CHECK_EN
        if (in_imm[0])                                    enc_err = ERR_ALIGN;
        else if (!(&in_imm[31:20] || ~|in_imm[31:20]))   enc_err = ERR_RANGE;
`endif
      end
      default: enc_err = ERR_OP;
    endcase
  end

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_inst  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && (enc_err == ERR_NONE);
  assign pop    = out_valid && out_ready;

  // FIFO pointer/occupancy update and error pulse generation
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    err_valid_d = accept && (enc_err != ERR_NONE);
    err_code_d  = err_valid_d ? enc_err : ERR_NONE;
  end

  // State registers; reset clears the queue, storage and any pending error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: directed known-answer steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_rv_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        err_exp;
  int          err_code_exp;

  rv_inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err_valid(err_valid), .err_code(err_code), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from the ISA field layout with plain arithmetic.
  function automatic void model_encode(input int op, input logic [31:0] rd,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm,
                                       output logic [31:0] w, output int code);
    int r_f3 [8];
    int i_f3 [7];
    int b_f3 [4];
    int s;
    logic [31:0] f3, f7;
    r_f3 = '{0, 0, 7, 6, 4, 1, 5, 5};
    i_f3 = '{0, 7, 6, 4, 1, 5, 5};
    b_f3 = '{0, 1, 4, 5};
    s = $signed(imm);
    w = 32'h0;
    code = 0;
    if (op <= 7) begin
      f7 = (op == 1 || op == 7) ? 32'd32 : 32'd0;
      f3 = r_f3[op];
      w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else if (op <= 11) begin
      f3 = i_f3[op-8];
      w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
`ifdef ENCODER_RANGE_CHECK_EN
      if (s < -2048 || s > 2047) code = 2;
`endif
    end else if (op <= 14) begin
      f3 = i_f3[op-8];
      f7 = (op == 14) ? 32'd32 : 32'd0;
      w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
`ifdef ENCODER_RANGE_CHECK_EN
      if (imm > 32'd31) code = 2;
`endif
    end else if (op == 15 || op == 16) begin
      w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) |
          ((op == 15) ? (32'd2 << 12) | 32'h03 : 32'h67);
`ifdef ENCODER_RANGE_CHECK_EN
      if (s < -2048 || s > 2047) code = 2;
`endif
    end else if (op == 17) begin
      w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12) |
          ((imm & 32'h1F) << 7) | 32'h23;
`ifdef ENCODER_RANGE_CHECK_EN
      if (s < -2048 || s > 2047) code = 2;
`endif
    end else if (op <= 21) begin
      f3 = b_f3[op-18];
      w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
          (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
          (((imm >> 11) & 1) << 7) | 32'h63;
`ifdef ENCODER_RANGE_CHECK_EN
      if (imm[0]) code = 3;
      else if (s < -4096 || s > 4095) code = 2;
`endif
    end else if (op == 22) begin
      w = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
`ifdef ENCODER_RANGE_CHECK_EN
      if ((imm & 32'hFFF) != 0) code = 2;
`endif
    end else if (op == 23) begin
      w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
          (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
`ifdef ENCODER_RANGE_CHECK_EN
      if (imm[0]) code = 3;
      else if (s < -1048576 || s > 1048575) code = 2;
`endif
    end else begin
      code = 1;
    end
  endfunction

  task automatic check_model();
    int n;
    n = exp_q.size();
    check("count", 32'(count), n);
    check("in_ready", 32'(in_ready), (n < DEPTH) ? 1 : 0);
    check("out_valid", 32'(out_valid), (n != 0) ? 1 : 0);
    if (n != 0) check("head", out_inst, exp_q[0]);
    check("err_valid", 32'(err_valid), 32'(err_exp));
    if (err_exp) check("err_code", 32'(err_code), err_code_exp);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [4:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic ordy);
    logic acc, pp;
    logic [31:0] w, tmp;
    int code;
    in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; out_ready = ordy;
    acc = v && (exp_q.size() < DEPTH);
    pp  = (exp_q.size() != 0) && ordy;
    model_encode(int'(op), 32'(rd), 32'(rs1), 32'(rs2), imm, w, code);
    @(posedge clk);
    if (pp) tmp = exp_q.pop_front();
    err_exp = 1'b0;
    if (acc) begin
      if (code == 0) exp_q.push_back(w);
      else begin
        err_exp = 1'b1;
        err_code_exp = code;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, ordy);
  endtask

  task automatic reset_checks();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_err_valid", 32'(err_valid), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_in_ready", 32'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    err_exp = 1'b0;
    err_code_exp = 0;
    reset_checks();
  endtask

  function automatic logic [31:0] rand_imm(input int op);
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = 32'($signed($urandom_range(0, 31)) - 16);
      1: v = 32'($signed($urandom_range(0, 4095)) - 2048);
      2: v = $urandom();
      default: begin
        case ($urandom_range(0, 11))
          0: v = 32'd2047;   1: v = 32'd2048;   2: v = -32'd2048;  3: v = -32'd2049;
          4: v = 32'd4094;   5: v = 32'd4096;   6: v = -32'd4096;  7: v = 32'd31;
          8: v = 32'd32;     9: v = 32'd1048574; 10: v = -32'd1048576;
          default: v = 32'd1048576;
        endcase
      end
    endcase
    if (op == 22 && $urandom_range(0, 1) == 1) v = v & 32'hFFFFF000;
    if ((op >= 18 && op <= 21) || op == 23)
      if ($urandom_range(0, 3) != 0) v = v & 32'hFFFFFFFE;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    err_exp = 1'b0; err_code_exp = 0;
    @(posedge clk);
    do_reset();

    // Known-answer encodings, consumer always ready
    step(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
    check("add_inst", out_inst, 32'h003100B3);
    check("add_valid", 32'(out_valid), 1);
    step(1'b1, 5'd8, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    check("addi_m1", out_inst, 32'hFFF00293);
    step(1'b1, 5'd17, 5'd0, 5'd1, 5'd2, 32'd4, 1'b1);
    check("sw", out_inst, 32'h0020A223);
    step(1'b1, 5'd22, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b1);
    check("lui", out_inst, 32'h123451B7);
    step(1'b1, 5'd18, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    check("beq8", out_inst, 32'h00208463);
    step(1'b1, 5'd23, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    check("jal2048", out_inst, 32'h001000EF);
    idle(1'b1);
    step(1'b1, 5'd18, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1);
`ifdef ENCODER_RANGE_CHECK_EN
    check("beq7_err", 32'(err_code), 3);
    check("beq7_valid", 32'(err_valid), 1);
`else
    check("beq7_inst", out_inst, 32'h00208363);
`endif
    idle(1'b1);
    step(1'b1, 5'd8, 5'd5, 5'd0, 5'd0, 32'd2048, 1'b1);
`ifdef ENCODER_RANGE_CHECK_EN
    check("addi2048_err", 32'(err_code), 2);
    check("addi2048_count", 32'(count), 0);
`else
    check("addi2048_inst", out_inst, 32'h80000293);
`endif
    idle(1'b1);
    step(1'b1, 5'd25, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
    check("op25_valid", 32'(err_valid), 1);
    check("op25_code", 32'(err_code), 1);
    step(1'b1, 5'd25, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1);
    check("op25_b2b", 32'(err_valid), 1);
    idle(1'b1);
    check("err_drop", 32'(err_valid), 0);

    // Full FIFO with back-pressure, then drain
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 5'd8, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0);
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(in_ready), 0);
    step(1'b1, 5'd8, 5'd9, 5'd0, 5'd0, 32'd5, 1'b0);
    check("full_hold", 32'(count), 4);
    step(1'b1, 5'd8, 5'd9, 5'd0, 5'd0, 32'd5, 1'b1);
    check("full_pop_only", 32'(count), 3);
    check("full_head2", out_inst, 32'h00200113);
    step(1'b1, 5'd8, 5'd9, 5'd0, 5'd0, 32'd5, 1'b1);
    check("fifth_accept", 32'(count), 3);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("drained", 32'(count), 0);

    // Reset with entries queued and an error pulse pending
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 5'(i), 5'd1, 5'd2, 32'h0, 1'b0);
    step(1'b1, 5'd30, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    check("pre_rst_err", 32'(err_valid), 1);
    check("pre_rst_count", 32'(count), 3);
    do_reset();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      int op;
      op = $urandom_range(0, 31);
      step(($urandom_range(0, 3) != 0), 5'(op), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), rand_imm(op),
           ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    check("final_empty", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
